uart_cmd_tx: RTL

Serial transmitter for the character-write command channel: accepts (column, row, character) triplets on a valid/ready interface, buffers them in a small FIFO and sends each as three back-to-back 8N1 UART bytes (column, row, char) at 115200 baud from the 25 MHz pixel clock. It is the sending end of the link the display top receives on `rx_i`. It is used for board-to-board text forwarding and for loopback self-test, with `tx_o` wired to `rx_i`.

---
 rtl/uart_cmd_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_tx.sv
// Command-channel UART transmitter: queues (col,row,char) triplets in a small FIFO
// and sends each as three contiguous 8N1 bytes, col first.
module uart_cmd_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] col_i,
  input  logic [7:0] row_i,
  input  logic [7:0] char_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] frame_q, frame_d;
  logic        tx_q, tx_d;
  logic        baud_done;
  logic [7:0]  cur_byte;

  assign push      = valid_i && ready_o;
  assign ready_o   = (count_q != DEPTH_C);
  assign busy_o    = (state_q != IDLE) || (count_q != '0);
  assign tx_o      = tx_q;
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {char_i, row_i, col_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q];
          byte_d  = 2'd0;
          state_d = START;
        end
      end
      START: begin
        bit_d = 3'd0;
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        if (baud_done) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end else if (count_q != '0) begin
            // Chain straight into the next triplet without an idle bit.
            pop     = 1'b1;
            frame_d = mem_q[rd_ptr_q];
            byte_d  = 2'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE || state_d != state_q || baud_done) baud_d = '0;
    else                                                     baud_d = baud_q + 16'd1;
  end

  // Line level is registered from the current state, so it lags the FSM by one cycle.
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = frame_q[7:0];
      2'd1:    cur_byte = frame_q[15:8];
      default: cur_byte = frame_q[23:16];
    endcase
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
